// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - request inputs and lamp/walk outputs of the phase scheduler
interface traffic_phase_scheduler_if;
  logic       veh;
  logic       ped_btn;
  logic       emg;
  logic       hwr;
  logic       hwy;
  logic       hwg;
  logic       swr;
  logic       swy;
  logic       swg;
  logic       walk;
  logic       dont_walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output veh, ped_btn, emg,
    input  hwr, hwy, hwg, swr, swy, swg, walk, dont_walk, ped_ack, phase
  );

  modport slave (
    input  veh, ped_btn, emg,
    output hwr, hwy, hwg, swr, swy, swg, walk, dont_walk, ped_ack, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - highway/side-road/pedestrian phase sequencer with emergency preempt
module traffic_phase_scheduler #(
  parameter int MIN_HG = 8,
  parameter int YEL    = 3,
  parameter int ALLRED = 1,
  parameter int SG     = 10,
  parameter int WALK   = 6,
  parameter int PCLR   = 4,
  parameter int CW     = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_phase_scheduler_if.slave    io
);

  typedef enum logic [2:0] {
    HW_GREEN    = 3'd0,
    HW_YELLOW   = 3'd1,
    ALL_RED     = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    PED_WALK    = 3'd5,
    PED_CLEAR   = 3'd6,
    ILLEGAL     = 3'd7
  } state_t;

  localparam logic [CW-1:0] HG_LAST   = CW'(MIN_HG - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(YEL - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(ALLRED - 1);
  localparam logic [CW-1:0] SG_LAST   = CW'(SG - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(WALK - 1);
  localparam logic [CW-1:0] PCLR_LAST = CW'(PCLR - 1);

  state_t        state_q, state_d;
  state_t        target_q, target_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          ped_req_q, ped_req_d;
  logic          last_ped_q, last_ped_d;
  logic          ped_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HW_GREEN;
      target_q   <= HW_GREEN;
      tmr_q      <= '0;
      ped_req_q  <= 1'b0;
      last_ped_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      tmr_q      <= tmr_d;
      ped_req_q  <= ped_req_d;
      last_ped_q <= last_ped_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    last_ped_d = last_ped_q;
    ped_entry  = (state_q == PED_WALK) && (tmr_q == '0);

    case (state_q)
      HW_GREEN: begin
        if ((tmr_q >= HG_LAST) && !io.emg && (io.veh || ped_req_q)) begin
          state_d = HW_YELLOW;
          // On a tie, alternate away from whichever was served last.
          if (io.veh && ped_req_q) target_d = last_ped_q ? SIDE_GREEN : PED_WALK;
          else                     target_d = io.veh ? SIDE_GREEN : PED_WALK;
        end
      end
      HW_YELLOW:   if (tmr_q == YEL_LAST) state_d = ALL_RED;
      ALL_RED:     if (tmr_q == AR_LAST)  state_d = io.emg ? HW_GREEN : target_q;
      SIDE_GREEN:  if (io.emg || (tmr_q == SG_LAST)) state_d = SIDE_YELLOW;
      SIDE_YELLOW: begin
        if (tmr_q == YEL_LAST) begin
          state_d  = ALL_RED;
          target_d = HW_GREEN;
        end
      end
      PED_WALK:    if (io.emg || (tmr_q == WALK_LAST)) state_d = PED_CLEAR;
      PED_CLEAR: begin
        if (tmr_q == PCLR_LAST) begin
          state_d  = ALL_RED;
          target_d = HW_GREEN;
        end
      end
      default: begin
        state_d  = ALL_RED;
        target_d = HW_GREEN;
      end
    endcase

    if ((state_d == SIDE_GREEN) && (state_q != SIDE_GREEN)) last_ped_d = 1'b0;
    if ((state_d == PED_WALK) && (state_q != PED_WALK))     last_ped_d = 1'b1;

    // Highway green may idle forever, so its timer parks at the minimum dwell.
    if (state_d != state_q)                               tmr_d = '0;
    else if ((state_q == HW_GREEN) && (tmr_q >= HG_LAST)) tmr_d = tmr_q;
    else                                                  tmr_d = tmr_q + CW'(1);

    ped_req_d = ped_entry ? 1'b0 : (ped_req_q | io.ped_btn);
  end

  always_comb begin
    io.hwg       = 1'b0;
    io.hwy       = 1'b0;
    io.hwr       = 1'b1;
    io.swg       = 1'b0;
    io.swy       = 1'b0;
    io.swr       = 1'b1;
    io.walk      = 1'b0;
    io.dont_walk = 1'b1;
    io.ped_ack   = ped_entry;
    io.phase     = state_q;

    case (state_q)
      HW_GREEN: begin
        io.hwg = 1'b1;
        io.hwr = 1'b0;
      end
      HW_YELLOW: begin
        io.hwy = 1'b1;
        io.hwr = 1'b0;
      end
      SIDE_GREEN: begin
        io.swg = 1'b1;
        io.swr = 1'b0;
      end
      SIDE_YELLOW: begin
        io.swy = 1'b1;
        io.swr = 1'b0;
      end
      PED_WALK: begin
        io.walk      = 1'b1;
        io.dont_walk = 1'b0;
      end
      PED_CLEAR:   io.dont_walk = tmr_q[0];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - model-checked directed and random bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  localparam int MIN_HG = 8;
  localparam int YEL    = 3;
  localparam int ALLRED = 1;
  localparam int SG     = 10;
  localparam int WALK   = 6;
  localparam int PCLR   = 4;
  localparam int CW     = 5;
  localparam logic [11:0] RST_OUTS = 12'h310;

  logic clk;
  logic rst;
  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .MIN_HG(MIN_HG), .YEL(YEL), .ALLRED(ALLRED), .SG(SG),
    .WALK(WALK), .PCLR(PCLR), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current phase, cycles spent in it, pending ped request, who was served last.
  int m_ph, m_t, m_tgt;
  bit m_ped, m_last_side;

  int          cyc;
  logic [11:0] s_out;
  logic [11:0] hist [0:99];
  int          idle_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  function automatic logic [11:0] dut_outs();
    return {bus.hwr, bus.hwy, bus.hwg, bus.swr, bus.swy, bus.swg,
            bus.walk, bus.dont_walk, bus.ped_ack, bus.phase};
  endfunction

  function automatic logic [11:0] exp_outs(input int ph, input int t);
    logic hg, hy, hr, sg, sy, sr, wk, dw, ack;
    hg  = (ph == 0);
    hy  = (ph == 1);
    hr  = !(hg || hy);
    sg  = (ph == 3);
    sy  = (ph == 4);
    sr  = !(sg || sy);
    wk  = (ph == 5);
    dw  = (ph == 6) ? ((t % 2) == 1) : !wk;
    ack = (ph == 5) && (t == 0);
    return {hr, hy, hg, sr, sy, sg, wk, dw, ack, 3'(ph)};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_tgt = 0; m_ped = 0; m_last_side = 0;
  endtask

  task automatic model_step();
    int nph;
    nph = m_ph;
    case (m_ph)
      0: if (m_t >= MIN_HG - 1 && !bus.emg && (bus.veh || m_ped)) begin
           nph = 1;
           if (bus.veh && m_ped) m_tgt = m_last_side ? 5 : 3;
           else                  m_tgt = bus.veh ? 3 : 5;
         end
      1: if (m_t == YEL - 1) nph = 2;
      2: if (m_t == ALLRED - 1) nph = bus.emg ? 0 : m_tgt;
      3: if (bus.emg || m_t == SG - 1) nph = 4;
      4: if (m_t == YEL - 1) begin nph = 2; m_tgt = 0; end
      5: if (bus.emg || m_t == WALK - 1) nph = 6;
      6: if (m_t == PCLR - 1) begin nph = 2; m_tgt = 0; end
      default: nph = 2;
    endcase
    m_ped = (m_ph == 5 && m_t == 0) ? 1'b0 : (m_ped | bus.ped_btn);
    if (nph == 3 && m_ph != 3) m_last_side = 1;
    if (nph == 5 && m_ph != 5) m_last_side = 0;
    m_t  = (nph == m_ph) ? m_t + 1 : 0;
    m_ph = nph;
  endtask

  task automatic cycle();
    @(negedge clk);
    s_out = dut_outs();
    chk("outs", s_out, exp_outs(m_ph, m_t));
    chk("hw_one_lamp", $countones({bus.hwr, bus.hwy, bus.hwg}), 1);
    chk("sw_one_lamp", $countones({bus.swr, bus.swy, bus.swg}), 1);
    if (cyc < 100) hist[cyc] = s_out;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    bus.veh = 0; bus.ped_btn = 0; bus.emg = 0;
    rst = 0;
    #2;
    chk("reset_outs", dut_outs(), RST_OUTS);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    cyc = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int c2[10] = '{7, 8, 11, 12, 21, 22, 25, 26, 34, 52};
    int p2[10] = '{0, 1, 2, 3, 3, 4, 2, 0, 1, 0};
    int c5[9]  = '{14, 15, 17, 18, 19, 31, 32, 35, 36};
    int p5[9]  = '{3, 4, 4, 2, 0, 0, 1, 2, 3};
    rst = 0; bus.veh = 0; bus.ped_btn = 0; bus.emg = 0; cyc = 0;
    model_reset();

    // Idle after reset
    apply_reset();
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (s_out !== RST_OUTS) idle_bad++;
    end
    chk("idle_hold", idle_bad, 0);

    // Vehicle held: period-26 side cycle
    apply_reset();
    bus.veh = 1;
    run(60);
    for (int i = 0; i < 10; i++) chk($sformatf("veh_phase_c%0d", c2[i]), hist[c2[i]][2:0], p2[i]);

    // Pedestrian pulse at cycle 2
    apply_reset();
    run(2);
    bus.ped_btn = 1;
    cycle();
    bus.ped_btn = 0;
    run(27);
    chk("ped_ack_c11", hist[11][3], 0);
    chk("ped_ack_c12", hist[12][3], 1);
    chk("ped_ack_c13", hist[13][3], 0);
    chk("walk_c17", hist[17][5], 1);
    chk("clear_c18", hist[18][2:0], 6);
    chk("dw_c18_21", {hist[18][4], hist[19][4], hist[20][4], hist[21][4]}, 4'b0101);
    chk("allred_c22", hist[22][2:0], 2);
    chk("hwg_c23", hist[23][9], 1);

    // Tie: side first, pedestrian after one highway dwell
    apply_reset();
    bus.veh = 1;
    run(3);
    bus.ped_btn = 1;
    cycle();
    bus.ped_btn = 0;
    run(9);
    bus.veh = 0;
    run(30);
    chk("tie_side_c12", hist[12][2:0], 3);
    chk("tie_hwg_c33", hist[33][2:0], 0);
    chk("tie_hwy_c34", hist[34][2:0], 1);
    chk("tie_walk_c38", hist[38][2:0], 5);

    // Emergency during side green
    apply_reset();
    bus.veh = 1;
    run(14);
    bus.emg = 1;
    run(17);
    bus.emg = 0;
    run(15);
    for (int i = 0; i < 9; i++) chk($sformatf("emg_phase_c%0d", c5[i]), hist[c5[i]][2:0], p5[i]);

    // Async reset in the middle of the walk phase with a fresh request pending
    apply_reset();
    run(2);
    bus.ped_btn = 1;
    cycle();
    bus.ped_btn = 0;
    run(10);
    bus.ped_btn = 1;
    cycle();
    bus.ped_btn = 0;
    #2;
    rst = 0;
    #1;
    chk("async_reset_outs", dut_outs(), RST_OUTS);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    cyc = 0;
    idle_bad = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (s_out !== RST_OUTS) idle_bad++;
    end
    chk("post_reset_idle", idle_bad, 0);

    // Randomized traffic against the model
    for (int blk = 0; blk < 3; blk++) begin
      apply_reset();
      for (int i = 0; i < 1000; i++) begin
        bus.veh     = ($urandom_range(0, 99) < 30);
        bus.ped_btn = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 99) < 4) bus.emg = ~bus.emg;
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Phase scheduler for a two-road intersection with a pedestrian crossing. It arbitrates between three requesters and drives every lamp and walk signal directly: side-road vehicle sensor, latched pedestrian button, and an emergency preempt. The highway is the default green; side road and pedestrian phases are served round-robin when both are pending. It sits above the lamp outputs as the intersection's sequencing controller.

## Interface
- MIN_HG, 8, minimum highway-green dwell (cycles)
- YEL, 3, yellow dwell for either road
- ALLRED, 1, all-red clearance dwell
- SG, 10, side-road green dwell
- WALK, 6, pedestrian walk dwell
- PCLR, 4, pedestrian clearance (flashing don't-walk) dwell
- CW, 5, timer width; must hold max(all dwells)-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- veh  in  1  side-road vehicle present (level)
- ped_btn  in  1  pedestrian button (any high cycle registers a request)
- emg  in  1  emergency preempt, forces highway green (level)
- hwr, hwy, hwg  out  1 each  highway red/yellow/green
- swr, swy, swg  out  1 each  side-road red/yellow/green
- walk, dont_walk  out  1 each  pedestrian signals
- ped_ack  out  1  one-cycle pulse on entry to PED_WALK
- phase  out  3  current state encoding

## Operation
- States (phase value): HW_GREEN 0, HW_YELLOW 1, ALL_RED 2, SIDE_GREEN 3, SIDE_YELLOW 4, PED_WALK 5, PED_CLEAR 6. Code 7 is illegal: it displays all red and goes to ALL_RED with target HW_GREEN.
- Timer tmr clears on every state change and otherwise increments. A timed state exits in the cycle where tmr == DUR-1, so the dwell is exactly DUR cycles.
- ped_req sets on any cycle with ped_btn=1. It clears in the PED_WALK entry cycle. If the button is pressed in that same cycle, the clear wins.
- veh is sampled only in HW_GREEN. It is ignored in all other states and is not latched.
- HW_GREEN: exits only when tmr ≥ MIN_HG-1, emg=0, and (veh or ped_req). The target is latched at exit:
  - only one request pending: serve that one;
  - both pending: serve the opposite of last_srv.
- With no request, HW_GREEN holds indefinitely; tmr saturates at MIN_HG-1.
- HW_YELLOW (YEL) → ALL_RED (ALLRED) → target. The target is forced to HW_GREEN if emg=1 on ALL_RED exit.
- SIDE_GREEN (SG) → SIDE_YELLOW (YEL) → ALL_RED → HW_GREEN. last_srv becomes SIDE on entry to SIDE_GREEN.
- PED_WALK (WALK) → PED_CLEAR (PCLR) → ALL_RED → HW_GREEN. last_srv becomes PED on entry to PED_WALK.
- Emergency preemption:
  - emg=1 in SIDE_GREEN: next state is SIDE_YELLOW.
  - emg=1 in PED_WALK: next state is PED_CLEAR.
  - Yellow, clear and all-red states always complete their full dwell.
  - HW_GREEN holds while emg=1.
- Lamp decode from state, purely combinational:
  - HW_GREEN: hwg, swr
  - HW_YELLOW: hwy, swr
  - SIDE_GREEN: hwr, swg
  - SIDE_YELLOW: hwr, swy
  - ALL_RED, PED_WALK, PED_CLEAR: hwr, swr
- Pedestrian signals:
  - walk=1 only in PED_WALK.
  - dont_walk=tmr[0] in PED_CLEAR (flashing), 0 in PED_WALK, and 1 elsewhere.
- Exactly one lamp per road is lit in every state.

## Timing
- Reset (rst=0, async): state HW_GREEN, tmr=0, ped_req=0, last_srv=PED (so side wins the first tie). Outputs on reset: hwg=1, swr=1, dont_walk=1, all others 0, phase=0, ped_ack=0.
- State, tmr, ped_req and last_srv are registered. Lamps follow state with zero combinational delay after the clock edge.
- Request latency: the soonest HW_GREEN→HW_YELLOW edge is the MIN_HG-th edge after HW_GREEN entry. A request arriving after that takes effect on the next edge.
- Full side cycle with defaults: hwg 8, hwy 3, all-red 1, swg 10, swy 3, all-red 1 = 26 cycles back to hwg.
- Full pedestrian cycle with defaults: hwg 8, hwy 3, all-red 1, walk 6, clear 4, all-red 1 = 23 cycles.
- rst asserted mid-phase returns to the reset state immediately, without waiting for a clock edge.

## Test plan
- Reset then idle: no veh/ped for 50 cycles → hwg=1, swr=1, dont_walk=1 throughout, phase=0.
- veh held high from reset release → hwg 8 cycles, hwy 3, all-red 1, swg 10, swy 3, all-red 1, then hwg again. The sequence repeats with period 26.
- ped_btn 1-cycle pulse at cycle 2 → ped_ack pulse on PED_WALK entry at cycle 12. walk high for 6 cycles, then dont_walk toggles for 4 cycles, then all-red 1 cycle, then hwg.
- veh high and ped pulse both before cycle 7 → side is served first. After a hwg dwell of 8 cycles, PED_WALK is served. ped_req stays set through the side phase.
- emg raised at swg cycle 3 → swy on the next edge, 3 cycles swy, all-red 1, then hwg held while emg=1 even with veh=1. Side is served after emg drops and the MIN_HG dwell has completed.
- rst pulsed low mid-PED_WALK → outputs return to reset values immediately and ped_req is cleared. With no new requests the block stays in HW_GREEN.
